// File: rtl/enigma_stream.sv
// enigma_stream: byte-serial wrapper around a 128-bit combinational cipher.
// Collects 16 input bytes into blk_out, waits SETTLE cycles for the cipher,
// captures res_in, then streams the 16 result bytes out with handshaking.
module enigma_stream #(
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   key_in,
  input  logic         mode_in,
  input  logic         flush,
  output logic [127:0] blk_out,
  output logic [7:0]   key_out,
  output logic         mode_out,
  input  logic [127:0] res_in,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_SEND} state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     idx;
  logic [3:0]     cnt;
  logic [127:0]   result;
  logic           accept;
  logic           xfer;
  logic           capture;
  logic [3:0]     settle_last;

  // Counter runs 0..SETTLE so the first out_valid lands SETTLE+1 cycles
  // after the edge that accepts byte 15.
  assign settle_last = 4'(SETTLE);

  // Handshake decode and output muxing
  always_comb begin
    in_ready  = (state == S_LOAD);
    out_valid = (state == S_SEND);
    accept    = in_valid & in_ready;
    xfer      = out_valid & out_ready;
    capture   = (state == S_SETTLE) && (cnt == settle_last);
    out_data  = out_valid ? result[{idx, 3'b000} +: 8] : '0;
    busy      = !((state == S_LOAD) && (idx == 4'd0));
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:   if (accept && idx == 4'd15) state_nx = S_SETTLE;
      S_SETTLE: if (capture)                state_nx = S_SEND;
      S_SEND:   if (xfer && idx == 4'd15)   state_nx = S_LOAD;
      default:                              state_nx = S_LOAD;
    endcase
    if (flush) state_nx = S_LOAD;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nx;
  end

  // Datapath: byte index, settle counter, block/key/mode latches, result
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      cnt      <= '0;
      result   <= '0;
      blk_out  <= '0;
      key_out  <= '0;
      mode_out <= 1'b0;
    end else if (flush) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          cnt <= '0;
          if (accept) begin
            blk_out[{idx, 3'b000} +: 8] <= in_data;
            if (idx == 4'd0) begin
              key_out  <= key_in;
              mode_out <= mode_in;
            end
            idx <= idx + 4'd1;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 4'd1;
          if (capture) result <= res_in;
        end
        S_SEND: begin
          if (xfer) idx <= idx + 4'd1;
        end
        default: begin
          idx <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
